// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and sizes for the serial work-frame receiver
package serial_pkg;
  localparam int FRAME_BYTES = 64;
  localparam int BYTE_W      = 8;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef logic [FRAME_BYTES*BYTE_W-1:0] frame_t;
endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver: RxD synchronizer, bit timer and receive FSM
module uart_rx_byte
  import serial_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RxD,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              rx_valid,
  output logic              rx_frame_err,
  output logic              rx_idle
);
  localparam int TW = $clog2(CLK_DIV);

  rx_state_t         state;
  logic              rx_meta, rx_sync;
  logic [TW-1:0]     timer;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] shreg;
  logic              armed;

  assign rx_idle = (state == RX_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      state        <= RX_IDLE;
      timer        <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      armed        <= 1'b1;
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_meta      <= RxD;
      rx_sync      <= rx_meta;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      // A framing error leaves the line low; only a high level may re-arm start detection.
      if (rx_sync) armed <= 1'b1;
      case (state)
        RX_IDLE: begin
          if (!rx_sync && armed) begin
            state <= RX_START;
            timer <= TW'(CLK_DIV/2 - 1);
          end
        end
        RX_START: begin
          if (timer == '0) begin
            if (!rx_sync) begin
              state   <= RX_DATA;
              timer   <= TW'(CLK_DIV - 1);
              bit_cnt <= '0;
            end else begin
              state <= RX_IDLE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        RX_DATA: begin
          if (timer == '0) begin
            shreg <= {rx_sync, shreg[BYTE_W-1:1]};
            timer <= TW'(CLK_DIV - 1);
            if (bit_cnt == 3'd7) state <= RX_STOP;
            else                 bit_cnt <= bit_cnt + 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        RX_STOP: begin
          if (timer == '0) begin
            state <= RX_IDLE;
            if (rx_sync) begin
              rx_byte  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
              armed        <= 1'b0;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/serial_receive.sv
// rtl/serial_receive.sv - assembles 64-byte UART work frames into midstate/data2
// Optional SERIAL_RX_TIMEOUT_EN: an idle gap mid-frame resets the byte counter.
module serial_receive
  import serial_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         RxD,
  output logic [255:0] midstate,
  output logic [255:0] data2
);
  localparam int CLK_DIV        = CLK_FREQ / BAUD;
  localparam int TIMEOUT_CYCLES = 16 * CLK_DIV;
  localparam int FW             = FRAME_BYTES * BYTE_W;

  logic [BYTE_W-1:0] rx_byte;
  logic              rx_valid, rx_frame_err, rx_idle;
  logic              byte_ok;
  frame_t            frame_buf, next_buf;
  logic [6:0]        byte_cnt;

  uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk          (clk),
    .reset        (reset),
    .RxD          (RxD),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_idle      (rx_idle)
  );

  // rx_valid is raised on the stop-sample edge, which also returns the FSM to idle.
  assign byte_ok  = rx_valid & ~rx_frame_err & rx_idle;
  assign next_buf = {frame_buf[FW-BYTE_W-1:0], rx_byte};

`ifdef SERIAL_RX_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        idle_run, timeout_hit;

  assign idle_run    = rx_idle && (byte_cnt != '0);
  assign timeout_hit = idle_run && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       idle_cnt <= '0;
    else if (!idle_run || timeout_hit) idle_cnt <= '0;
    else                             idle_cnt <= idle_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_buf <= '0;
      byte_cnt  <= '0;
      midstate  <= '0;
      data2     <= '0;
    end else if (byte_ok) begin
      frame_buf <= next_buf;
      if (byte_cnt == 7'(FRAME_BYTES - 1)) begin
        midstate <= next_buf[FW-1:FW/2];
        data2    <= next_buf[FW/2-1:0];
        byte_cnt <= '0;
      end else begin
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
`ifdef SERIAL_RX_TIMEOUT_EN
    else if (timeout_hit) begin
      byte_cnt <= '0;
    end
`endif
  end
endmodule

// File: tb/tb_serial_receive.sv
// tb/tb_serial_receive.sv - directed self-checking bench for serial_receive (CLK_DIV = 8)
module tb_serial_receive;
  localparam int DIV = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         RxD = 1'b1;
  logic [255:0] midstate, data2;
  int           n_checks = 0;
  int           n_errors = 0;

  serial_receive #(.CLK_FREQ(800), .BAUD(100)) dut (
    .clk      (clk),
    .reset    (reset),
    .RxD      (RxD),
    .midstate (midstate),
    .data2    (data2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    RxD = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int gap_bits);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_ok);
    RxD = 1'b1;
    repeat (gap_bits * DIV) @(negedge clk);
  endtask

  function automatic logic [511:0] seq_frame(input logic [7:0] base);
    logic [511:0] f = '0;
    for (int i = 0; i < 64; i++) f = {f[503:0], 8'(base + i)};
    return f;
  endfunction

  logic [511:0] exp_f;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // idle line after reset
    for (int k = 0; k < 10; k++) begin
      repeat (100) @(negedge clk);
      check("idle_mid", midstate, '0);
      check("idle_d2", data2, '0);
    end

    // frame 1: 0x00..0x3F
    for (int i = 0; i < 63; i++) send_byte(8'(i), 1'b1, 0);
    repeat (2) @(negedge clk);
    check("f1_pre_mid", midstate, '0);
    check("f1_pre_d2", data2, '0);
    send_byte(8'h3F, 1'b1, 0);
    repeat (2) @(negedge clk);
    check("f1_mid", midstate, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    check("f1_d2", data2, 256'h202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f);

    // frame 2: all 0xA5 with a 2-bit idle gap between bytes
    for (int i = 0; i < 63; i++) send_byte(8'hA5, 1'b1, 2);
    check("f2_pre_mid", midstate, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    check("f2_pre_d2", data2, 256'h202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f);
    send_byte(8'hA5, 1'b1, 2);
    check("f2_mid", midstate, {32{8'hA5}});
    check("f2_d2", data2, {32{8'hA5}});

    // frame 3: 0x40..0x7F, byte 10 first sent with a bad stop bit, plus an idle glitch
    for (int i = 0; i < 64; i++) begin
      if (i == 10) begin
        send_byte(8'h4A, 1'b0, 1);
        RxD = 1'b0;
        repeat (2) @(negedge clk);
        RxD = 1'b1;
        repeat (3 * DIV) @(negedge clk);
      end
      if (i == 63) begin
        check("f3_pre_mid", midstate, {32{8'hA5}});
        check("f3_pre_d2", data2, {32{8'hA5}});
      end
      send_byte(8'(8'h40 + i), 1'b1, 1);
    end
    exp_f = seq_frame(8'h40);
    check("f3_mid", midstate, exp_f[511:256]);
    check("f3_d2", data2, exp_f[255:0]);

    // reset after 20 bytes, mid-byte
    for (int i = 0; i < 20; i++) send_byte(8'hEE, 1'b1, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    reset = 1'b1;
    #1;
    check("rst_mid", midstate, '0);
    check("rst_d2", data2, '0);
    RxD = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    check("rst_hold_mid", midstate, '0);
    for (int i = 0; i < 64; i++) send_byte(8'(8'h80 + i), 1'b1, 0);
    exp_f = seq_frame(8'h80);
    check("f4_mid", midstate, exp_f[511:256]);
    check("f4_d2", data2, exp_f[255:0]);

    // partial frame, long idle gap, then a full frame
    for (int i = 0; i < 5; i++) send_byte(8'(8'hE0 + i), 1'b1, 0);
    repeat (16 * DIV + 10) @(negedge clk);
    for (int i = 0; i < 64; i++) send_byte(8'(i), 1'b1, 0);
`ifdef SERIAL_RX_TIMEOUT_EN
    exp_f = seq_frame(8'h00);
`else
    exp_f = '0;
    for (int i = 0; i < 5; i++)  exp_f = {exp_f[503:0], 8'(8'hE0 + i)};
    for (int i = 0; i < 59; i++) exp_f = {exp_f[503:0], 8'(i)};
`endif
    check("to_mid", midstate, exp_f[511:256]);
    check("to_d2", data2, exp_f[255:0]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/serial_receive.md
Name: serial_receive

Overview:
UART (8N1) receiver that assembles a 64-byte work frame from the host into two 256-bit words, midstate and data2. It feeds the mining control unit.
Both outputs are registered and update together, only when a complete frame has been received. Between frames they hold their last value.

Parameters:
CLK_FREQ, 50000000, clk frequency in Hz
BAUD, 115200, serial bit rate
CLK_DIV, CLK_FREQ/BAUD (integer division, 434), clocks per bit; derived localparam; must be >= 4
FRAME_BYTES, 64, bytes per frame (fixed localparam)
TIMEOUT_CYCLES, 16*CLK_DIV, idle gap that resynchronises a partial frame (used only with the optional feature)

Ports:
clk  input  1  hash clock; all logic is on its rising edge
reset  input  1  asynchronous, active-high reset
RxD  input  1  asynchronous serial line; idles high
midstate  output  256  last complete frame, bytes 0..31
data2  output  256  last complete frame, bytes 32..63

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high.
- Reset values:
  - midstate = 0, data2 = 0.
  - Byte counter = 0, shift buffer = 0, receiver FSM = IDLE.
- RxD passes through a 2-flop synchronizer (reset value 1) before any use.
- Receiver FSM has four states: IDLE, START, DATA, STOP.
  - IDLE: a synchronized low level moves to START; the bit timer is loaded.
  - START: wait CLK_DIV/2 clocks, then resample. Low -> DATA. High -> glitch; return to IDLE with no byte counted.
  - DATA: sample every CLK_DIV clocks, 8 bits, LSB first.
  - STOP: sample after CLK_DIV more clocks.
    - High -> byte valid for one cycle; go to IDLE.
    - Low -> framing error; discard the byte, leave the counter unchanged, go to IDLE. Do not re-trigger on the same low level: wait for RxD high before re-arming.
- Frame assembly, on each valid byte:
  - Shift the byte in: buf[511:0] <= {buf[503:0], byte}; increment the byte counter.
  - The first byte of a frame ends in buf[511:504]; the last byte ends in buf[7:0].
  - When the counter reaches 64, on the same edge: midstate <= next buf[511:256], data2 <= next buf[255:0], counter <= 0.
- Latency: outputs change on the clock edge right after the stop-bit sample of byte 64.
- Partial frames never disturb the outputs.
- Reset mid-byte or mid-frame: the partial frame is discarded and the outputs are cleared to 0.
- Byte counter is 7 bits and wraps only via the frame-complete rule; no other overflow is possible.
- Back-to-back frames are allowed. A start bit immediately after a stop bit is accepted.

Optional Feature:
SERIAL_RX_TIMEOUT_EN
- Defined: an idle counter runs while the FSM is in IDLE and the byte counter is non-zero. It is cleared by every start bit. When it reaches TIMEOUT_CYCLES, the byte counter is set to 0, so the next byte is treated as byte 0. The outputs are unchanged.
- Undefined: the timeout logic is absent. Only reset or frame completion clears the byte counter.

Decomposition:
- Package serial_pkg:
  - FRAME_BYTES = 64
  - BYTE_W = 8
  - the typedef of the 4-state receiver FSM enum
  - the frame_t 512-bit vector typedef
- One sub-module, uart_rx_byte: synchronizer, FSM and bit timer.
  - Outputs: rx_byte[7:0], rx_valid (one-cycle pulse), rx_frame_err (one-cycle pulse).
  - serial_receive holds the shift buffer, byte counter, timeout logic and output registers.

Test Plan:
- Reset only, RxD high for 1000 clocks (CLK_DIV=8) -> midstate == 0 and data2 == 0 throughout.
- Send bytes 0x00..0x3F -> one edge after byte 63's stop sample: midstate == 256'h000102...1F, data2 == 256'h202122...3F. Both are unchanged before that edge.
- Send a second frame of all 0xA5, with a 2-bit idle gap between bytes -> both outputs become all 0xA5 only after byte 64.
- Corrupt the stop bit of byte 10, resend it correctly, then send the rest of the frame -> outputs match a 64-byte frame without the corrupted byte. A 2-clock low glitch on RxD in IDLE -> no byte counted.
- Assert reset after 20 bytes, then send a full frame -> outputs are 0 before the frame and equal to the new frame after it.
- With SERIAL_RX_TIMEOUT_EN:
  - Send 5 bytes, idle TIMEOUT_CYCLES+10, send 64 bytes 0x00..0x3F -> outputs equal the 0x00..0x3F frame.
  - Same stimulus without the macro -> the frame completes at byte 59, with the first 5 bytes in midstate[255:216].
